// File: rtl/led_matrix_scanner_if.sv
// CPU-side write/commit bus of the LED matrix scanner.
// The master (CPU I/O path) writes back-buffer rows and requests a frame
// swap; the slave (scanner) reports whether a swap is still outstanding.
interface led_matrix_scanner_if #(
    parameter int NUM_ROWS  = 9,
    parameter int COL_WIDTH = 8
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic                 wr_en;
    logic [ROW_W-1:0]     wr_row;
    logic [COL_WIDTH-1:0] wr_data;
    logic                 commit;
    logic                 busy;

    modport master (
        output wr_en,
        output wr_row,
        output wr_data,
        output commit,
        input  busy
    );

    modport slave (
        input  wr_en,
        input  wr_row,
        input  wr_data,
        input  commit,
        output busy
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed LED matrix driver with a double-buffered frame.
// One row is scanned per PERIOD clocks with blank gaps at both ends of the
// slot; a committed back buffer is copied to the front only at a frame
// boundary so a half-written frame is never shown.
// Optional feature: define LED_SCAN_DIM_EN to add a 4-bit brightness input
// that shortens the lit window of each row slot.
module led_matrix_scanner #(
    parameter int NUM_ROWS  = 9,
    parameter int COL_WIDTH = 8,
    parameter int PERIOD    = 27000,
    parameter int GAP_ON    = 100,
    parameter int GAP_OFF   = 2000
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
`ifdef LED_SCAN_DIM_EN
    input  logic [3:0]           dim,
`endif
    led_matrix_scanner_if.slave  bus,
    output logic                 frame_start,
    output logic [NUM_ROWS-1:0]  led_row,
    output logic [COL_WIDTH-1:0] led_col
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] ON_START = CNT_W'(GAP_ON);

    logic [CNT_W-1:0] counter;
    logic [ROW_W-1:0] row_idx;

    logic [NUM_ROWS-1:0][COL_WIDTH-1:0] front;
    logic [NUM_ROWS-1:0][COL_WIDTH-1:0] back;
    logic [NUM_ROWS-1:0][COL_WIDTH-1:0] back_next;

    logic pending;
    logic row_end;
    logic frame_end;
    logic swap;
    logic wr_ok;
    logic on;

    // Slot/frame boundary detection, swap decision and write-address check
    always_comb begin
        row_end   = (counter == CNT_LAST);
        frame_end = row_end && (row_idx == ROW_LAST);
        swap      = frame_end && (pending || bus.commit);
        wr_ok     = bus.wr_en && (32'(bus.wr_row) < NUM_ROWS);
    end

    // Back buffer as it will look after this edge, so a swap on the same edge sees the write
    always_comb begin
        back_next = back;
        if (wr_ok) begin
            back_next[bus.wr_row] = bus.wr_data;
        end
    end

`ifdef LED_SCAN_DIM_EN
    localparam int ACTIVE = PERIOD - GAP_ON - GAP_OFF;
    localparam int LEN_W  = CNT_W + 5;

    logic [3:0]       dim_q;
    logic [3:0]       dim_eff;
    logic [LEN_W-1:0] on_len;
    logic [LEN_W-1:0] on_stop;

    // Lit window scaled by the brightness captured at the start of the slot
    always_comb begin
        dim_eff = (counter == '0) ? dim : dim_q;
        on_len  = (LEN_W'(ACTIVE) * (LEN_W'(dim_eff) + LEN_W'(1))) >> 4;
        on_stop = LEN_W'(GAP_ON) + on_len;
        on      = (counter >= ON_START) && (LEN_W'(counter) < on_stop);
    end

    // Hold the brightness sampled at counter==0 for the rest of the slot
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            dim_q <= 4'hF;
        end else if (counter == '0) begin
            dim_q <= dim;
        end
    end
`else
    localparam logic [CNT_W-1:0] ON_STOP = CNT_W'(PERIOD - GAP_OFF);

    // Full lit window between the two blanking gaps
    always_comb begin
        on = (counter >= ON_START) && (counter < ON_STOP);
    end
`endif

    // Slot counter and row index; the row advances on the last clock of each slot
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            counter <= '0;
            row_idx <= '0;
        end else if (row_end) begin
            counter <= '0;
            row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    // Frame buffers, pending swap request and the registered frame-start pulse
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            front       <= '0;
            back        <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            back        <= back_next;
            frame_start <= frame_end;
            if (swap) begin
                front   <= back_next;
                pending <= 1'b0;
            end else if (bus.commit) begin
                pending <= 1'b1;
            end
        end
    end

    assign led_row  = ~(NUM_ROWS'(on) << row_idx);
    assign led_col  = front[row_idx];
    assign bus.busy = pending;

endmodule
